// File: rtl/router_src_arbiter.sv
// Packet-granular round-robin arbiter sharing the router input port between three sources.
// Beat count comes from the header length field, so a source cannot hold the port indefinitely.
module router_src_arbiter #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic [2:0] src_pkt_valid,
  input  logic [7:0] src_data_0,
  input  logic [7:0] src_data_1,
  input  logic [7:0] src_data_2,
  input  logic       router_busy,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic [2:0] gnt,
  output logic [2:0] src_ready,
  output logic [1:0] active_src,
  output logic       proto_err
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_PARITY, S_DRAIN} state_t;

  localparam int DW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [5:0]    count;
  logic [DW-1:0] drain_cnt;

  logic [7:0] sel_data;
  logic       sel_pv;
  logic       in_pkt;
  logic       beat;
  logic [1:0] c1, c2, pick;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    sel_data = 8'd0;
    sel_pv   = 1'b0;
    case (active_src)
      2'd0: begin sel_data = src_data_0; sel_pv = src_pkt_valid[0]; end
      2'd1: begin sel_data = src_data_1; sel_pv = src_pkt_valid[1]; end
      2'd2: begin sel_data = src_data_2; sel_pv = src_pkt_valid[2]; end
      default: ;
    endcase
    in_pkt = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_PARITY);
    beat   = in_pkt && !router_busy;
    // Round-robin scan starting at rr_ptr; only consumed when req is non-zero.
    c1 = next_src(rr_ptr);
    c2 = next_src(c1);
    if (req[rr_ptr])  pick = rr_ptr;
    else if (req[c1]) pick = c1;
    else              pick = c2;
  end

  assign pkt_valid = (state == S_HDR) || (state == S_PAYLOAD);
  assign data_in   = in_pkt ? sel_data : 8'd0;
  assign src_ready = beat ? gnt : 3'b000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      gnt        <= 3'b000;
      active_src <= 2'd3;
      rr_ptr     <= 2'd0;
      count      <= 6'd0;
      drain_cnt  <= '0;
      proto_err  <= 1'b0;
    end else begin
      // Source pkt_valid must be high on header/payload beats and low on the parity beat.
      proto_err <= beat && (sel_pv != (state != S_PARITY));
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt        <= 3'b001 << pick;
            active_src <= pick;
            state      <= S_HDR;
          end
        end
        S_HDR: begin
          if (beat) begin
            count <= sel_data[7:2];
            state <= (sel_data[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (beat) begin
            count <= count - 6'd1;
            if (count == 6'd1) state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (beat) begin
            state      <= S_DRAIN;
            rr_ptr     <= next_src(active_src);
            gnt        <= 3'b000;
            active_src <= 2'd3;
            drain_cnt  <= '0;
          end
        end
        S_DRAIN: begin
          // Gap lets the router finish its parity states before another header arrives.
          if (drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + 1'b1;
          else if (!router_busy)       state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: directed test-plan steps then randomized traffic,
// every cycle compared against a packet-position reference model.
module tb_router_src_arbiter;

  localparam int GAP = 2;

  logic       clock;
  logic       resetn;
  logic [2:0] req;
  logic [2:0] src_pkt_valid;
  logic [7:0] src_data_0, src_data_1, src_data_2;
  logic       router_busy;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] gnt;
  logic [2:0] src_ready;
  logic [1:0] active_src;
  logic       proto_err;

  router_src_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clock(clock), .resetn(resetn), .req(req), .src_pkt_valid(src_pkt_valid),
    .src_data_0(src_data_0), .src_data_1(src_data_1), .src_data_2(src_data_2),
    .router_busy(router_busy), .pkt_valid(pkt_valid), .data_in(data_in), .gnt(gnt),
    .src_ready(src_ready), .active_src(active_src), .proto_err(proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Source side: one packet per source, byte position advanced on src_ready.
  logic [7:0] pkt [3][66];
  int         slen [3];
  int         flip_at [3];
  int         src_pos [3];
  bit         regen;

  // Reference model: mode 0 idle, 1 in packet, 2 gap after parity.
  int m_mode, m_act, m_pos, m_len, m_rr, m_drain;
  bit m_perr;

  int beats, pv_beats, perr_cnt, last_beats, last_pv, last_perr;
  int grant_log [$];
  logic [2:0] prev_gnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_pkt(input int i, input int len, input int dest, input int flip);
    logic [7:0] par;
    logic [5:0] l6;
    logic [1:0] d2;
    l6 = len[5:0];
    d2 = dest[1:0];
    slen[i]    = len;
    flip_at[i] = flip;
    pkt[i][0]  = {l6, d2};
    par = pkt[i][0];
    for (int k = 1; k <= len; k++) begin
      pkt[i][k] = 8'($urandom);
      par ^= pkt[i][k];
    end
    pkt[i][len + 1] = par;
  endtask

  task automatic new_random_pkt(input int i);
    int r, len, flip;
    r = $urandom_range(0, 9);
    len = (r == 0) ? 63 : ((r < 3) ? 0 : $urandom_range(1, 6));
    flip = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len + 1) : -1;
    new_pkt(i, len, $urandom_range(0, 3), flip);
  endtask

  task automatic drive_sources();
    logic [2:0] pv;
    for (int i = 0; i < 3; i++)
      pv[i] = (src_pos[i] <= slen[i]) ^ (src_pos[i] == flip_at[i]);
    src_pkt_valid = pv;
    src_data_0 = pkt[0][src_pos[0]];
    src_data_1 = pkt[1][src_pos[1]];
    src_data_2 = pkt[2][src_pos[2]];
  endtask

  task automatic reset_model();
    m_mode = 0; m_act = -1; m_pos = 0; m_len = 0; m_rr = 0; m_drain = 0; m_perr = 0;
    for (int i = 0; i < 3; i++) src_pos[i] = 0;
    beats = 0; pv_beats = 0; perr_cnt = 0; prev_gnt = 3'b000;
  endtask

  // One clock: entered and left at the falling edge, inputs already set by the caller.
  task automatic cycle();
    logic [2:0] eg, adv;
    logic [7:0] ed;
    logic       ep;
    bit         fin, found;
    drive_sources();
    #1;
    eg = 3'b000; ed = 8'd0; ep = 1'b0;
    if (m_mode == 1) begin
      eg = 3'(1 << m_act);
      ed = pkt[m_act][m_pos];
      ep = (m_pos <= m_len);
    end
    check("gnt", 8'(gnt), 8'(eg));
    check("active_src", 8'(active_src), (m_mode == 1) ? 8'(m_act) : 8'd3);
    check("pkt_valid", 8'(pkt_valid), 8'(ep));
    check("data_in", data_in, ed);
    check("src_ready", 8'(src_ready), (m_mode == 1 && !router_busy) ? 8'(eg) : 8'd0);
    check("proto_err", 8'(proto_err), 8'(m_perr));
    check("gnt_onehot", 8'($countones(gnt) <= 1), 8'd1);

    if (src_ready != 3'b000) begin
      beats++;
      if (pkt_valid) pv_beats++;
    end
    if (proto_err) perr_cnt++;
    if (gnt != 3'b000 && prev_gnt == 3'b000) grant_log.push_back(int'(active_src));
    prev_gnt = gnt;
    adv = src_ready;

    m_perr = 1'b0;
    fin = 1'b0;
    case (m_mode)
      0: if (req != 3'b000) begin
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
          int c;
          c = (m_rr + k) % 3;
          if (!found && req[c]) begin
            found = 1'b1;
            m_act = c;
          end
        end
        m_len  = int'(pkt[m_act][0][7:2]);
        m_pos  = 0;
        m_mode = 1;
      end
      1: if (!router_busy) begin
        m_perr = (src_pkt_valid[m_act] !== (m_pos <= m_len));
        if (m_pos == m_len + 1) begin
          m_rr = (m_act + 1) % 3;
          m_act = -1;
          m_mode = 2;
          m_drain = 0;
          fin = 1'b1;
        end else begin
          m_pos++;
        end
      end
      default: begin
        m_drain++;
        if (m_drain >= GAP && !router_busy) m_mode = 0;
      end
    endcase

    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (adv[i]) begin
        if (src_pos[i] == slen[i] + 1) begin
          src_pos[i] = 0;
          if (regen) new_random_pkt(i);
        end else begin
          src_pos[i]++;
        end
      end
    end
    if (fin) begin
      last_beats = beats; last_pv = pv_beats; last_perr = perr_cnt;
      beats = 0; pv_beats = 0; perr_cnt = 0;
    end
    @(negedge clock);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_pos(input int pos, input string tag);
    int n;
    n = 0;
    while (!(m_mode == 1 && m_pos == pos) && n < 200) begin
      cycle();
      n++;
    end
    check(tag, 8'(n < 200), 8'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = 3'b000;
    router_busy = 1'b0;
    reset_model();
    drive_sources();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    int exp_order [4];
    exp_order = '{0, 1, 2, 0};
    regen = 1'b0;
    for (int i = 0; i < 3; i++) new_pkt(i, 1, i, -1);
    do_reset();
    run_cycles(2);

    // Single source 1, header 0x0D.
    new_pkt(1, 3, 1, -1);
    req = 3'b010;
    cycle();
    req = 3'b000;
    check("t1_gnt", 8'(gnt), 8'h02);
    check("t1_hdr", data_in, 8'h0D);
    run_cycles(9);
    check("t1_beats", 8'(last_beats), 8'd5);
    check("t1_pv_beats", 8'(last_pv), 8'd4);

    // All three requesting from reset.
    do_reset();
    for (int i = 0; i < 3; i++) new_pkt(i, 1, i, -1);
    grant_log.delete();
    req = 3'b111;
    run_cycles(24);
    req = 3'b000;
    run_cycles(8);
    check("t2_grants", 8'(grant_log.size() >= 4), 8'd1);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++) check("t2_order", 8'(grant_log[k]), 8'(exp_order[k]));

    // Source 2 with busy stall during payload beat 2.
    new_pkt(2, 4, 2, -1);
    req = 3'b100;
    cycle();
    req = 3'b000;
    wait_pos(2, "t3_wait");
    for (int k = 0; k < 3; k++) begin
      router_busy = 1'b1;
      cycle();
      check("t3_ready", 8'(src_ready[2]), 8'd0);
      check("t3_hold", data_in, pkt[2][2]);
    end
    router_busy = 1'b0;
    run_cycles(8);
    check("t3_beats", 8'(last_beats), 8'd6);
    check("t3_pv_beats", 8'(last_pv), 8'd5);

    // Zero-length packet from source 0.
    new_pkt(0, 0, 0, -1);
    req = 3'b001;
    cycle();
    req = 3'b000;
    run_cycles(6);
    check("t4_beats", 8'(last_beats), 8'd2);
    check("t4_pv_beats", 8'(last_pv), 8'd1);

    // Source 1 drops pkt_valid on payload beat 1.
    new_pkt(1, 2, 1, 1);
    req = 3'b010;
    cycle();
    req = 3'b000;
    run_cycles(8);
    check("t5_beats", 8'(last_beats), 8'd4);
    check("t5_pv_beats", 8'(last_pv), 8'd3);
    check("t5_perr", 8'(last_perr), 8'd1);

    // Asynchronous reset in the middle of a payload.
    new_pkt(0, 5, 0, -1);
    req = 3'b001;
    cycle();
    req = 3'b000;
    wait_pos(2, "t6_wait");
    #3 resetn = 1'b0;
    #1;
    check("t6_gnt", 8'(gnt), 8'd0);
    check("t6_pkt_valid", 8'(pkt_valid), 8'd0);
    check("t6_active", 8'(active_src), 8'd3);
    check("t6_ready", 8'(src_ready), 8'd0);
    check("t6_data", data_in, 8'd0);
    reset_model();
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    new_pkt(0, 1, 0, -1);
    new_pkt(1, 1, 1, -1);
    req = 3'b011;
    cycle();
    req = 3'b000;
    check("t6_first", 8'(gnt), 8'h01);
    run_cycles(10);

    // Maximum length: 65 beats.
    new_pkt(2, 63, 3, -1);
    req = 3'b100;
    cycle();
    req = 3'b000;
    run_cycles(70);
    check("t7_beats", 8'(last_beats), 8'd65);
    check("t7_pv_beats", 8'(last_pv), 8'd64);

    // Randomized traffic.
    regen = 1'b1;
    for (int i = 0; i < 3; i++) new_random_pkt(i);
    for (int k = 0; k < 800; k++) begin
      req = 3'($urandom);
      router_busy = ($urandom_range(0, 3) == 0);
      cycle();
    end
    regen = 1'b0;
    req = 3'b000;
    router_busy = 1'b0;
    run_cycles(80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
